// File: rtl/vga_bus_arbiter_pkg.sv
// Shared definitions for the VGA/CPU RAM arbiter: default bus widths,
// FSM encoding and the saturating wait-counter helper.
package vga_bus_arbiter_pkg;

  localparam int unsigned VGA_ADDR_WIDTH = 16;
  localparam int unsigned VGA_DATA_WIDTH = 8;
  localparam int unsigned WAIT_WIDTH     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } arb_state_e;

  function automatic logic [WAIT_WIDTH-1:0] sat_inc(input logic [WAIT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_bus_arbiter.sv
// Arbitrates a single synchronous RAM port between a VGA master (absolute
// priority) and a CPU that is served only in cycles VGA has not announced.
module vga_bus_arbiter
  import vga_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = VGA_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = VGA_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_vga_addr,
  input  logic                  i_vga_cs,
  input  logic                  i_vga_access,
  output logic [DATA_WIDTH-1:0] o_vga_dat,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_dat,
  input  logic                  i_cpu_we,
  input  logic                  i_cpu_cs,
  output logic [DATA_WIDTH-1:0] o_cpu_dat,
  output logic                  o_cpu_ack,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_dat,
  output logic                  o_ram_cs,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_dat,
  output logic                  o_collision,
  output logic [WAIT_WIDTH-1:0] o_cpu_wait_max
);

  arb_state_e            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  we_q;
  logic                  ack_q;
  logic                  collision_q;
  logic [WAIT_WIDTH-1:0] wait_q;
  logic [WAIT_WIDTH-1:0] wait_max_q;
  logic [ADDR_WIDTH-1:0] last_addr_q;

  logic [ADDR_WIDTH-1:0] ram_addr_d;
  logic                  ram_cs_d;
  logic                  ram_we_d;

  // VGA overrides the port combinationally, even on top of a CPU grant.
  always_comb begin
    ram_addr_d = last_addr_q;
    ram_cs_d   = 1'b0;
    ram_we_d   = 1'b0;
    if (i_vga_cs) begin
      ram_addr_d = i_vga_addr;
      ram_cs_d   = 1'b1;
    end else if (state_q == GRANT) begin
      ram_addr_d = addr_q;
      ram_cs_d   = 1'b1;
      ram_we_d   = we_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      ack_q       <= 1'b0;
      collision_q <= 1'b0;
      wait_q      <= '0;
      wait_max_q  <= '0;
      last_addr_q <= '0;
    end else begin
      ack_q       <= 1'b0;
      last_addr_q <= ram_addr_d;
      case (state_q)
        IDLE: begin
          if (i_cpu_cs && !i_vga_access) begin
            addr_q  <= i_cpu_addr;
            dat_q   <= i_cpu_dat;
            we_q    <= i_cpu_we;
            wait_q  <= '0;
            state_q <= GRANT;
            if (wait_q > wait_max_q) wait_max_q <= wait_q;
          end else if (i_cpu_cs) begin
            wait_q <= sat_inc(wait_q);
          end else begin
            wait_q <= '0;
          end
        end
        GRANT: begin
          // An unannounced VGA cycle stole the port: drop and let CPU retry.
          if (i_vga_cs) begin
            collision_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            ack_q   <= 1'b1;
            state_q <= ACK;
          end
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_vga_dat      = i_ram_dat;
  assign o_cpu_dat      = i_ram_dat;
  assign o_cpu_ack      = ack_q;
  assign o_ram_addr     = ram_addr_d;
  assign o_ram_dat      = dat_q;
  assign o_ram_cs       = ram_cs_d;
  assign o_ram_we       = ram_we_d;
  assign o_collision    = collision_q;
  assign o_cpu_wait_max = wait_max_q;

endmodule

// File: tb/tb_vga_bus_arbiter.sv
// Self-checking bench: behavioural synchronous RAM, VGA pattern driver and
// a scoreboard of expected CPU read data checked on each acknowledge.
module tb_vga_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] vga_addr;
  logic        vga_cs;
  logic        vga_access;
  logic [7:0]  vga_dat;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdat;
  logic        cpu_we;
  logic        cpu_cs;
  logic [7:0]  cpu_rdat;
  logic        cpu_ack;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdat;
  logic        ram_cs;
  logic        ram_we;
  logic [7:0]  ram_rd;
  logic        collision;
  logic [7:0]  wait_max;

  logic        pre_we;
  logic [15:0] pre_addr;
  logic [7:0]  pre_dat;
  logic [7:0]  mem [0:65535];

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;
  exp_t        exp_q[$];
  logic [7:0]  ref_mem [logic [15:0]];

  int checks   = 0;
  int failures = 0;
  int we_count = 0;
  int ack_count = 0;

  always #5 clk = ~clk;

  vga_bus_arbiter dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_vga_addr    (vga_addr),
    .i_vga_cs      (vga_cs),
    .i_vga_access  (vga_access),
    .o_vga_dat     (vga_dat),
    .i_cpu_addr    (cpu_addr),
    .i_cpu_dat     (cpu_wdat),
    .i_cpu_we      (cpu_we),
    .i_cpu_cs      (cpu_cs),
    .o_cpu_dat     (cpu_rdat),
    .o_cpu_ack     (cpu_ack),
    .o_ram_addr    (ram_addr),
    .o_ram_dat     (ram_wdat),
    .o_ram_cs      (ram_cs),
    .o_ram_we      (ram_we),
    .i_ram_dat     (ram_rd),
    .o_collision   (collision),
    .o_cpu_wait_max(wait_max)
  );

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_dat;
    end else if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_wdat;
      ram_rd <= mem[ram_addr];
    end
  end

  always @(negedge clk) begin
    if (ram_we) we_count <= we_count + 1;
    if (cpu_ack) ack_count <= ack_count + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_dat = d;
    tick();
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // One CPU transaction; lat/grant_n count cycles from the request cycle.
  task automatic cpu_op(input string tag, input logic [15:0] a, input logic [7:0] d,
                        input bit we, input int budget, output int lat, output int grant_n,
                        output logic [15:0] grant_addr);
    exp_t e;
    bit   got = 1'b0;
    int   n;
    grant_n = -1; grant_addr = '0; lat = -1;
    cpu_addr = a; cpu_wdat = d; cpu_we = we; cpu_cs = 1'b1;
    e.we = we; e.addr = a;
    e.data = ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    if (we) ref_mem[a] = d;
    exp_q.push_back(e);
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      if (ram_cs && !vga_cs && grant_n < 0) begin
        grant_n = n; grant_addr = ram_addr;
      end
      if (cpu_ack) begin
        got = 1'b1;
        lat = n;
        e = exp_q.pop_front();
        if (!e.we) check_eq({tag, "_rdata"}, cpu_rdat, e.data);
        break;
      end
      tick();
    end
    if (!got) begin
      check_eq({tag, "_ack_seen"}, got, 1'b1);
      void'(exp_q.pop_front());
    end
    $display("txn %s addr=0x%04h we=%0d wdat=0x%02h rdat=0x%02h lat=%0d grant=%0d",
             tag, a, we, d, cpu_rdat, lat, grant_n);
    tick();
    cpu_cs = 1'b0; cpu_we = 1'b0;
    tick();
  endtask

  // VGA stream: access announced one cycle before each cs.
  task automatic vga_pattern(input int n, input bit alt, input logic [15:0] base);
    logic prev = 1'b0;
    for (int i = 0; i < n; i++) begin
      vga_cs     = prev;
      vga_addr   = base + 16'(i);
      vga_access = alt ? ((i % 2) == 0) : 1'b1;
      prev       = vga_access;
      tick();
    end
    vga_cs = prev; vga_access = 1'b0;
    tick();
    vga_cs = 1'b0;
  endtask

  initial begin
    int          lat, gn, we0, ack0;
    logic [15:0] ga;
    rst = 1'b1;
    vga_addr = 16'h0; vga_cs = 1'b0; vga_access = 1'b0;
    cpu_addr = 16'h0; cpu_wdat = 8'h0; cpu_we = 1'b0; cpu_cs = 1'b0;
    pre_we = 1'b0; pre_addr = 16'h0; pre_dat = 8'h0; ram_rd = 8'h0;

    preload(16'h1234, 8'hA5);
    preload(16'h2000, 8'h11);
    preload(16'h0100, 8'h77);
    for (int i = 0; i < 8; i++) preload(16'h0040 + 16'(i), 8'h30 + 8'(i * 7));

    @(negedge clk);
    check_eq("rst_ack", cpu_ack, 1'b0);
    check_eq("rst_ram_cs", ram_cs, 1'b0);
    check_eq("rst_ram_we", ram_we, 1'b0);
    check_eq("rst_collision", collision, 1'b0);
    check_eq("rst_wait_max", wait_max, 8'd0);
    vga_cs = 1'b1; vga_addr = 16'h0ABC;
    #1;
    check_eq("rst_vga_owns_cs", ram_cs, 1'b1);
    check_eq("rst_vga_owns_addr", ram_addr, 16'h0ABC);
    vga_cs = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Plain read, nominal latency
    cpu_op("rd1234", 16'h1234, 8'h00, 1'b0, 20, lat, gn, ga);
    check_eq("rd1234_lat", lat, 2);
    check_eq("rd1234_grant_cycle", gn, 1);
    check_eq("rd1234_grant_addr", ga, 16'h1234);

    // Write stalled by three announced VGA cycles
    we0 = we_count;
    fork
      vga_pattern(3, 1'b0, 16'h0800);
      cpu_op("wr2000", 16'h2000, 8'h5A, 1'b1, 40, lat, gn, ga);
    join
    check_eq("wr2000_lat", lat, 5);
    check_eq("wr2000_grant_cycle", gn, 4);
    check_eq("wr2000_we_pulses", we_count - we0, 1);
    check_eq("wr2000_wait_max", wait_max, 8'd3);
    cpu_op("rd2000", 16'h2000, 8'h00, 1'b0, 20, lat, gn, ga);
    check_eq("rd2000_lat", lat, 2);

    // Interleaved character/font fetches against back-to-back CPU reads
    fork
      vga_pattern(20, 1'b1, 16'h0300);
      for (int i = 0; i < 4; i++)
        cpu_op("rd_mix", 16'h0040 + 16'(i), 8'h00, 1'b0, 40, lat, gn, ga);
    join
    check_eq("mix_collision", collision, 1'b0);

    // Unannounced VGA cycle during GRANT
    fork
      cpu_op("rd_coll", 16'h0045, 8'h00, 1'b0, 40, lat, gn, ga);
      begin
        tick();
        vga_cs = 1'b1; vga_addr = 16'h0100;
        @(negedge clk);
        check_eq("coll_port_addr", ram_addr, 16'h0100);
        check_eq("coll_port_we", ram_we, 1'b0);
        tick();
        vga_cs = 1'b0;
      end
    join
    check_eq("coll_lat", lat, 4);
    check_eq("coll_flag", collision, 1'b1);
    cpu_op("rd_after_coll", 16'h0046, 8'h00, 1'b0, 20, lat, gn, ga);
    check_eq("coll_sticky", collision, 1'b1);

    // Long VGA burst saturates the wait statistic
    fork
      vga_pattern(300, 1'b0, 16'h1000);
      cpu_op("rd_starve", 16'h0047, 8'h00, 1'b0, 400, lat, gn, ga);
    join
    check_eq("starve_lat", lat, 302);
    check_eq("starve_wait_max", wait_max, 8'd255);

    // Reset in the middle of a grant
    ack0 = ack_count;
    cpu_addr = 16'h1234; cpu_we = 1'b0; cpu_cs = 1'b1;
    tick();
    @(negedge clk);
    check_eq("rstgrant_ram_cs_before", ram_cs, 1'b1);
    #1;
    rst = 1'b1; cpu_cs = 1'b0;
    #1;
    check_eq("rstgrant_ram_cs", ram_cs, 1'b0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check_eq("rstgrant_no_ack", ack_count - ack0, 0);
    check_eq("rstgrant_wait_max", wait_max, 8'd0);
    check_eq("rstgrant_collision", collision, 1'b0);
    cpu_op("rd_post_rst", 16'h0040, 8'h00, 1'b0, 20, lat, gn, ga);
    check_eq("post_rst_lat", lat, 2);

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
